// File: rtl/rotate_ddr_wrbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rotbuf_pkg
// Purpose  : Shared beat type, widths and byte-merge helper for the rotator
//            DDRAM write buffer.
// Revision : 1.0  initial release
// ============================================================================
package rotbuf_pkg;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] din;
    } wr_beat_t;

    localparam int BEAT_W = $bits(wr_beat_t);

    // New bytes win where enabled; bytes never written by either stay zero.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_din,
        input logic [BE_W-1:0]   old_be,
        input logic [DATA_W-1:0] new_din,
        input logic [BE_W-1:0]   new_be
    );
        logic [DATA_W-1:0] result;
        result = '0;
        for (int i = 0; i < BE_W; i++) begin
            if (new_be[i])
                result[i*8 +: 8] = new_din[i*8 +: 8];
            else if (old_be[i])
                result[i*8 +: 8] = old_din[i*8 +: 8];
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rotate_ddr_wrbuf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_fwft
// Purpose  : Single-clock first-word-fall-through FIFO; a write into a full
//            FIFO is accepted only when a read frees a slot in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_wr;
    logic             w_do_rd;

    // Equal index with differing wrap bit means every slot is occupied.
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_level = r_wr_ptr - r_rd_ptr;

    assign w_do_rd = i_rd_en && !o_empty;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr)
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/rotate_ddr_wrbuf.sv
`default_nettype none
// ============================================================================
// Module   : rotate_ddr_wrbuf
// Purpose  : Coalesces rotator half-word writes into 64-bit beats, queues them
//            and drains them to DDRAM under DDRAM_BUSY; drops are sticky.
//            Optional ROTBUF_STATS_EN adds drop_cnt and hiwater outputs.
// Revision : 1.0  initial release
// ============================================================================
module rotate_ddr_wrbuf
    import rotbuf_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int IDLE_FLUSH = 8
) (
    input  logic                    clk_video,
    input  logic                    reset_n,
    input  logic                    in_we,
    input  logic [28:0]             in_addr,
    input  logic [7:0]              in_be,
    input  logic [63:0]             in_din,
    input  logic                    flush,
    input  logic                    DDRAM_BUSY,
    output logic [28:0]             DDRAM_ADDR,
    output logic [63:0]             DDRAM_DIN,
    output logic [7:0]              DDRAM_BE,
    output logic                    DDRAM_WE,
    output logic [7:0]              DDRAM_BURSTCNT,
    output logic                    DDRAM_RD,
    output logic                    overflow,
    input  logic                    clr_overflow,
    output logic [$clog2(DEPTH):0]  level
`ifdef ROTBUF_STATS_EN
    ,
    output logic [15:0]             drop_cnt,
    output logic [$clog2(DEPTH):0]  hiwater
`endif
);

    localparam logic [7:0] c_idle_flush = 8'(IDLE_FLUSH);

    logic      r_pend_valid;
    wr_beat_t  r_pend;
    logic [7:0] r_idle;
    logic      r_flush_defer;
    logic      r_we;
    wr_beat_t  r_out;
    logic      r_overflow;

    logic      w_pend_valid_nxt;
    wr_beat_t  w_pend_nxt;
    logic [7:0] w_idle_nxt;
    logic [7:0] w_idle_inc;
    logic      w_defer_nxt;
    logic      w_flush_req;
    logic      w_push;
    logic      w_pop;
    logic      w_drop;
    logic      w_full;
    logic      w_empty;
    wr_beat_t  w_head;

    assign w_idle_inc  = r_idle + 8'd1;
    // A flush that coincided with a write is replayed on the following cycle.
    assign w_flush_req = flush || r_flush_defer;

    always_comb begin
        w_pend_valid_nxt = r_pend_valid;
        w_pend_nxt       = r_pend;
        w_idle_nxt       = r_idle;
        w_defer_nxt      = 1'b0;
        w_push           = 1'b0;
        if (in_we) begin
            w_idle_nxt  = 8'd0;
            w_defer_nxt = w_flush_req;
            if (r_pend_valid && (r_pend.addr == in_addr)) begin
                w_pend_nxt.be  = r_pend.be | in_be;
                w_pend_nxt.din = merge_bytes(r_pend.din, r_pend.be, in_din, in_be);
            end else begin
                w_push           = r_pend_valid;
                w_pend_valid_nxt = 1'b1;
                w_pend_nxt.addr  = in_addr;
                w_pend_nxt.be    = in_be;
                w_pend_nxt.din   = in_din;
            end
        end else if (r_pend_valid) begin
            if (w_flush_req || (w_idle_inc == c_idle_flush)) begin
                w_push           = 1'b1;
                w_pend_valid_nxt = 1'b0;
                w_idle_nxt       = 8'd0;
            end else begin
                w_idle_nxt = w_idle_inc;
            end
        end else begin
            w_idle_nxt = 8'd0;
        end
    end

    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_valid  <= 1'b0;
            r_pend        <= '0;
            r_idle        <= 8'd0;
            r_flush_defer <= 1'b0;
        end else begin
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend        <= w_pend_nxt;
            r_idle        <= w_idle_nxt;
            r_flush_defer <= w_defer_nxt;
        end
    end

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk       (clk_video),
        .rst_n     (reset_n),
        .i_wr_en   (w_push),
        .i_wr_data (r_pend),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (level)
    );

    // Refill the output register whenever it is empty or its beat is taken now.
    assign w_pop  = !w_empty && (!r_we || !DDRAM_BUSY);
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            r_we       <= 1'b0;
            r_out      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out <= w_head;
                r_we  <= 1'b1;
            end else if (r_we && !DDRAM_BUSY) begin
                r_we <= 1'b0;
            end
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clr_overflow)
                r_overflow <= 1'b0;
        end
    end

    assign DDRAM_ADDR     = r_out.addr;
    assign DDRAM_DIN      = r_out.din;
    assign DDRAM_BE       = r_out.be;
    assign DDRAM_WE       = r_we;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_RD       = 1'b0;
    assign overflow       = r_overflow;

`ifdef ROTBUF_STATS_EN
    logic [15:0]            r_drop_cnt;
    logic [$clog2(DEPTH):0] r_hiwater;

    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= 16'd0;
            r_hiwater  <= '0;
        end else begin
            if (clr_overflow)
                r_drop_cnt <= {15'd0, w_drop};
            else if (w_drop && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
            if (clr_overflow)
                r_hiwater <= '0;
            else if (level > r_hiwater)
                r_hiwater <= level;
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign hiwater  = r_hiwater;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rotate_ddr_wrbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotate_ddr_wrbuf
// Purpose  : Directed scoreboard bench for rotate_ddr_wrbuf.
// Revision : 1.0  initial release
// ============================================================================
module tb_rotate_ddr_wrbuf;

    localparam int K_WE   = 0;
    localparam int K_ADDR = 1;
    localparam int K_LVL  = 2;
    localparam int K_OVF  = 3;
    localparam int K_SBE  = 4;
    localparam int K_DROP = 5;
    localparam int K_HW   = 6;

    typedef struct {
        logic [28:0] addr;
        logic [7:0]  be;
        logic [63:0] din;
    } beat_t;

    typedef struct {
        int          kind;
        logic [63:0] exp;
    } chk_t;

    logic        clk_video = 1'b0;
    logic        reset_n   = 1'b0;
    logic        in_we     = 1'b0;
    logic [28:0] in_addr   = '0;
    logic [7:0]  in_be     = '0;
    logic [63:0] in_din    = '0;
    logic        flush     = 1'b0;
    logic        DDRAM_BUSY = 1'b0;
    logic        clr_overflow = 1'b0;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;
    logic [7:0]  DDRAM_BURSTCNT;
    logic        DDRAM_RD;
    logic        overflow;
    logic [4:0]  level;
`ifdef ROTBUF_STATS_EN
    logic [15:0] drop_cnt;
    logic [4:0]  hiwater;
`endif

    beat_t exp_q[$];
    chk_t  chk_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk_video = ~clk_video;

    rotate_ddr_wrbuf #(
        .DEPTH      (16),
        .IDLE_FLUSH (8)
    ) dut (
        .clk_video      (clk_video),
        .reset_n        (reset_n),
        .in_we          (in_we),
        .in_addr        (in_addr),
        .in_be          (in_be),
        .in_din         (in_din),
        .flush          (flush),
        .DDRAM_BUSY     (DDRAM_BUSY),
        .DDRAM_ADDR     (DDRAM_ADDR),
        .DDRAM_DIN      (DDRAM_DIN),
        .DDRAM_BE       (DDRAM_BE),
        .DDRAM_WE       (DDRAM_WE),
        .DDRAM_BURSTCNT (DDRAM_BURSTCNT),
        .DDRAM_RD       (DDRAM_RD),
        .overflow       (overflow),
        .clr_overflow   (clr_overflow),
        .level          (level)
`ifdef ROTBUF_STATS_EN
        ,
        .drop_cnt       (drop_cnt),
        .hiwater        (hiwater)
`endif
    );

    // Monitor: sole owner of the counters; compares accepted beats and status.
    beat_t       m_e;
    chk_t        m_c;
    logic [63:0] m_act;
    always @(negedge clk_video) begin
        if (reset_n && DDRAM_WE && !DDRAM_BUSY) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got addr=%h be=%h din=%h, required no beat",
                         DDRAM_ADDR, DDRAM_BE, DDRAM_DIN);
            end else begin
                m_e = exp_q.pop_front();
                if (DDRAM_ADDR !== m_e.addr || DDRAM_BE !== m_e.be || DDRAM_DIN !== m_e.din) begin
                    errors++;
                    $display("FAIL beat: got addr=%h be=%h din=%h, required addr=%h be=%h din=%h",
                             DDRAM_ADDR, DDRAM_BE, DDRAM_DIN, m_e.addr, m_e.be, m_e.din);
                end
            end
        end
        while (chk_q.size() != 0) begin
            m_c = chk_q.pop_front();
            case (m_c.kind)
                K_WE:   m_act = {63'd0, DDRAM_WE};
                K_ADDR: m_act = {35'd0, DDRAM_ADDR};
                K_LVL:  m_act = {59'd0, level};
                K_OVF:  m_act = {63'd0, overflow};
                K_SBE:  m_act = 64'(exp_q.size());
`ifdef ROTBUF_STATS_EN
                K_DROP: m_act = {48'd0, drop_cnt};
                K_HW:   m_act = {59'd0, hiwater};
`endif
                default: m_act = '1;
            endcase
            checks++;
            if (m_act !== m_c.exp) begin
                errors++;
                $display("FAIL status kind=%0d: got %0h, required %0h", m_c.kind, m_act, m_c.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_video);
        #1;
    endtask

    task automatic chk(input int kind, input logic [63:0] exp);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_beat(input logic [28:0] a, input logic [7:0] be, input logic [63:0] d);
        beat_t b;
        b.addr = a;
        b.be   = be;
        b.din  = d;
        exp_q.push_back(b);
    endtask

    task automatic wr(input logic [28:0] a, input logic [7:0] be, input logic [63:0] d);
        in_we   = 1'b1;
        in_addr = a;
        in_be   = be;
        in_din  = d;
        cyc();
        in_we = 1'b0;
    endtask

    task automatic drain_wait(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++)
            cyc();
        chk(K_SBE, 64'd0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        chk(K_WE, 64'd0);
        chk(K_LVL, 64'd0);
        chk(K_OVF, 64'd0);
        chk(K_ADDR, 64'd0);
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();

        // Coalesce two half-writes, emitted only after the idle timeout
        wr(29'h100, 8'h0F, 64'h0000_0000_1122_3344);
        wr(29'h100, 8'hF0, 64'hAABB_CCDD_0000_0000);
        expect_beat(29'h100, 8'hFF, 64'hAABB_CCDD_1122_3344);
        repeat (5) cyc();
        chk(K_WE, 64'd0);
        cyc();
        drain_wait(40);

        // Back-pressure: head held while busy, then four back-to-back beats
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr(29'(i), 8'hFF, 64'h1000 + 64'(i));
            expect_beat(29'(i), 8'hFF, 64'h1000 + 64'(i));
        end
        for (int i = 0; i < 20; i++) begin
            chk(K_WE, 64'd1);
            chk(K_ADDR, 64'd0);
            cyc();
        end
        DDRAM_BUSY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk(K_WE, 64'd1);
            chk(K_ADDR, 64'(i));
            cyc();
        end
        chk(K_WE, 64'd0);
        cyc();
        drain_wait(10);

        // Overflow: 1 in output reg, 16 queued, 0x211/0x212 dropped, 0x213 pending
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 20; i++)
            wr(29'h200 + 29'(i), 8'hFF, 64'hBEEF_0000 + 64'(i));
        for (int i = 0; i <= 16; i++)
            expect_beat(29'h200 + 29'(i), 8'hFF, 64'hBEEF_0000 + 64'(i));
        expect_beat(29'h213, 8'hFF, 64'hBEEF_0013);
        chk(K_LVL, 64'd16);
        chk(K_OVF, 64'd1);
`ifdef ROTBUF_STATS_EN
        chk(K_DROP, 64'd2);
        chk(K_HW, 64'd16);
`endif
        cyc();
        DDRAM_BUSY = 1'b0;
        drain_wait(60);
        chk(K_OVF, 64'd1);
        chk(K_LVL, 64'd0);
        cyc();
        clr_overflow = 1'b1;
        cyc();
        clr_overflow = 1'b0;
        chk(K_OVF, 64'd0);
`ifdef ROTBUF_STATS_EN
        chk(K_DROP, 64'd0);
        chk(K_HW, 64'd0);
`endif
        cyc();

        // Flush colliding with a write to a new address
        wr(29'h5, 8'hFF, 64'h5555);
        flush = 1'b1;
        wr(29'h6, 8'hFF, 64'h6666);
        flush = 1'b0;
        expect_beat(29'h5, 8'hFF, 64'h5555);
        expect_beat(29'h6, 8'hFF, 64'h6666);
        cyc();
        chk(K_WE, 64'd1);
        chk(K_ADDR, 64'h5);
        cyc();
        chk(K_WE, 64'd1);
        chk(K_ADDR, 64'h6);
        cyc();
        chk(K_WE, 64'd0);
        chk(K_OVF, 64'd0);
        cyc();
        drain_wait(20);

        // Full FIFO: push and pop in the same cycle
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 18; i++)
            wr(29'h300 + 29'(i), 8'hFF, 64'h3000 + 64'(i));
        for (int i = 0; i < 19; i++)
            expect_beat(29'h300 + 29'(i), 8'hFF, 64'h3000 + 64'(i));
        chk(K_LVL, 64'd16);
        chk(K_OVF, 64'd0);
        cyc();
        DDRAM_BUSY = 1'b0;
        wr(29'h312, 8'hFF, 64'h3012);
        DDRAM_BUSY = 1'b1;
        chk(K_LVL, 64'd16);
        chk(K_OVF, 64'd0);
        cyc();
        DDRAM_BUSY = 1'b0;
        drain_wait(80);
        chk(K_OVF, 64'd0);
        cyc();

        // Reset mid-drain abandons everything
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 4; i++)
            wr(29'h400 + 29'(i), 8'hFF, 64'h4000 + 64'(i));
        chk(K_WE, 64'd1);
        chk(K_ADDR, 64'h400);
        chk(K_LVL, 64'd2);
        cyc();
        #2;
        reset_n = 1'b0;
        chk(K_WE, 64'd0);
        chk(K_LVL, 64'd0);
        chk(K_ADDR, 64'd0);
        cyc();
        cyc();
        reset_n = 1'b1;
        DDRAM_BUSY = 1'b0;
        repeat (30) cyc();
        chk(K_WE, 64'd0);
        chk(K_LVL, 64'd0);
        chk(K_SBE, 64'd0);
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
